// File: rtl/x_testbench_bridge_pkg.sv
// Shared types and constants for the UART command bridge.
// Opcodes, FSM states, response codes and header field positions.
package x_testbench_bridge_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_SNAP    = 2'b10,
    OP_CAPTURE = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_EXEC,
    S_RESP
  } state_e;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int CH_HI  = 5;
  localparam int CH_LO  = 0;

endpackage

// File: rtl/x_word_serialiser.sv
// Parallel-load word to LSB-first byte stream with valid/accept.
// Valid drops for one cycle after each accept, so it never depends on accept.
module x_word_serialiser #(
  parameter int p_bytes = 4,
  parameter int p_len_w = $clog2(p_bytes + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [8*p_bytes-1:0] i_data,
  input  logic [p_len_w-1:0]   i_len,
  output logic                 o_valid,
  output logic [7:0]           o_data,
  input  logic                 i_accept,
  output logic                 o_done
);

  logic [8*p_bytes-1:0] data_q, data_d;
  logic [p_len_w-1:0]   rem_q, rem_d;
  logic                 valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    if (i_load) begin
      data_d  = i_data;
      rem_d   = i_len;
      valid_d = (i_len != '0);
    end else if (valid_q && i_accept) begin
      data_d  = data_q >> 8;
      rem_d   = rem_q - 1'b1;
      valid_d = 1'b0;
    end else if (rem_q != '0) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q[7:0];
  assign o_done  = valid_q && i_accept &&
                   (rem_q == p_len_w'(1));

endmodule

// File: rtl/x_testbench_bridge.sv
// UART command bridge: frame decode, per-channel writes, live and
// snapshot reads, and a serialised byte response path.
module x_testbench_bridge
  import x_testbench_bridge_pkg::*;
#(
  parameter int p_data_w   = 32,
  parameter int p_channels = 4,
  parameter int p_timeout  = 1200000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_rx_valid,
  input  logic [7:0]                     i_rx_data,
  output logic                           o_tx_valid,
  output logic [7:0]                     o_tx_data,
  input  logic                           i_tx_accept,
  input  logic [p_channels*p_data_w-1:0] i_dut_data,
  output logic [p_channels*p_data_w-1:0] o_dut_data,
  output logic                           o_busy,
  output logic                           o_err
);

  localparam int NB = p_data_w / 8;
  localparam int LW = $clog2(NB + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(p_timeout + 1);
  localparam int CW = (p_channels > 1) ? $clog2(p_channels) : 1;
  localparam logic [6:0] NCH = 7'(p_channels);

  state_e              state_q, state_d;
  opcode_e             op_q;
  logic [5:0]          ch_q;
  logic [p_data_w-1:0] word_q, word_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic                err_q, err_d;

  logic [p_data_w-1:0] dout_q [p_channels];
  logic [p_data_w-1:0] snap_q [p_channels];
  logic [p_data_w-1:0] din    [p_channels];

  logic          ch_ok, last_byte, timeout;
  logic          nak, rd_ok, sn_ok;
  logic [CW-1:0] ch_idx;
  logic          ser_load, ser_done;
  logic [p_data_w-1:0] resp_data;
  logic [LW-1:0]       resp_len;

  for (genvar k = 0; k < p_channels; k++) begin : g_pack
    assign din[k] = i_dut_data[k*p_data_w +: p_data_w];
    assign o_dut_data[k*p_data_w +: p_data_w] = dout_q[k];
  end

  assign ch_idx    = ch_q[CW-1:0];
  assign ch_ok     = {1'b0, ch_q} < NCH;
  assign last_byte = (bcnt_q == BW'(NB - 1));
  assign timeout   = (state_q == S_PAYLOAD) && !i_rx_valid &&
                     (idle_q == TW'(p_timeout - 1));
  assign nak   = !ch_ok && (op_q != OP_CAPTURE);
  assign rd_ok = ch_ok && (op_q == OP_READ);
  assign sn_ok = ch_ok && (op_q == OP_SNAP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (i_rx_valid)
          state_d = (opcode_e'(i_rx_data[OPC_HI:OPC_LO]) == OP_WRITE)
                    ? S_PAYLOAD : S_EXEC;
      S_PAYLOAD:
        if (i_rx_valid && last_byte) state_d = S_EXEC;
        else if (timeout)            state_d = S_IDLE;
      S_EXEC:
        state_d = S_RESP;
      S_RESP:
        if (ser_done) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state_q != S_IDLE);
    ser_load  = (state_q == S_EXEC);
    resp_data = p_data_w'(ACK);
    resp_len  = LW'(1);
    unique case (1'b1)
      nak:     resp_data = p_data_w'(NAK);
      rd_ok: begin
        resp_data = din[ch_idx];
        resp_len  = LW'(NB);
      end
      sn_ok: begin
        resp_data = snap_q[ch_idx];
        resp_len  = LW'(NB);
      end
      default: resp_data = p_data_w'(ACK);
    endcase
  end

  // Payload bytes enter at the top so the first byte ends up as the LSB.
  always_comb begin
    word_d = word_q;
    bcnt_d = bcnt_q;
    idle_d = '0;
    if (state_q == S_IDLE || timeout) begin
      word_d = '0;
      bcnt_d = '0;
    end else if (state_q == S_PAYLOAD && i_rx_valid) begin
      word_d = (word_q >> 8) |
               (p_data_w'(i_rx_data) << (p_data_w - 8));
      bcnt_d = bcnt_q + 1'b1;
    end
    if (state_q == S_PAYLOAD && !i_rx_valid)
      idle_d = idle_q + 1'b1;
    err_d = timeout ||
            ((state_q == S_EXEC) && nak) ||
            ((state_q == S_EXEC || state_q == S_RESP) && i_rx_valid);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_WRITE;
      ch_q    <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < p_channels; k++) begin
        dout_q[k] <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && i_rx_valid) begin
        op_q <= opcode_e'(i_rx_data[OPC_HI:OPC_LO]);
        ch_q <= i_rx_data[CH_HI:CH_LO];
      end
      if (state_q == S_EXEC && op_q == OP_WRITE && ch_ok)
        dout_q[ch_idx] <= word_q;
      if (state_q == S_EXEC && op_q == OP_CAPTURE)
        for (int k = 0; k < p_channels; k++)
          snap_q[k] <= din[k];
    end
  end

  assign o_err = err_q;

  x_word_serialiser #(
    .p_bytes (NB),
    .p_len_w (LW)
  ) u_ser (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (ser_load),
    .i_data   (resp_data),
    .i_len    (resp_len),
    .o_valid  (o_tx_valid),
    .o_data   (o_tx_data),
    .i_accept (i_tx_accept),
    .o_done   (ser_done)
  );

endmodule

// File: tb/tb_x_testbench_bridge.sv
// Bench for the UART command bridge: directed scenarios plus random
// frames checked against a channel/snapshot array model.
module tb_x_testbench_bridge;

  localparam int W  = 32;
  localparam int NC = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_accept = 1'b0;
  logic [NC*W-1:0] dut_in = '0;
  logic [NC*W-1:0] dut_out;
  logic          busy, err;

  int n_chk = 0;
  int n_pass = 0;
  int err_cnt = 0;

  logic [W-1:0] m_dout [NC];
  logic [W-1:0] m_snap [NC];

  logic [7:0] got_q [$];
  logic       got_tmo;
  int         got_unst;

  x_testbench_bridge #(
    .p_data_w   (W),
    .p_channels (NC),
    .p_timeout  (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_tx_valid  (tx_valid),
    .o_tx_data   (tx_data),
    .i_tx_accept (tx_accept),
    .i_dut_data  (dut_in),
    .o_dut_data  (dut_out),
    .o_busy      (busy),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int stall);
    logic [7:0] b;
    int w;
    got_q.delete();
    got_tmo  = 1'b0;
    got_unst = 0;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!tx_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!tx_valid) begin
        got_tmo = 1'b1;
        return;
      end
      b = tx_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (tx_data !== b || tx_valid !== 1'b1) got_unst++;
      end
      tx_accept = 1'b1;
      got_q.push_back(tx_data);
      @(negedge clk);
      tx_accept = 1'b0;
    end
  endtask

  function automatic logic [NC*W-1:0] model_packed();
    logic [NC*W-1:0] m;
    for (int k = 0; k < NC; k++) m[k*W +: W] = m_dout[k];
    return m;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NC; k++) begin
      m_dout[k] = '0;
      m_snap[k] = '0;
    end
  endtask

  task automatic do_frame(input logic [1:0] op, input logic [5:0] ch,
                          input logic [W-1:0] pay, input int stall,
                          input string tag);
    logic [7:0] exp_q [$];
    logic [W-1:0] v;
    logic bad;
    int e0;
    bad = (op != 2'b11) && (int'(ch) >= NC);
    if (bad) exp_q.push_back(8'hEE);
    else begin
      case (op)
        2'b00: begin
          exp_q.push_back(8'hA5);
          m_dout[ch] = pay;
        end
        2'b01, 2'b10: begin
          v = (op == 2'b01) ? dut_in[ch*W +: W] : m_snap[ch];
          for (int i = 0; i < W/8; i++) exp_q.push_back(v[8*i +: 8]);
        end
        default: begin
          exp_q.push_back(8'hA5);
          for (int k = 0; k < NC; k++) m_snap[k] = dut_in[k*W +: W];
        end
      endcase
    end
    e0 = err_cnt;
    send_byte({op, ch});
    if (op == 2'b00)
      for (int i = 0; i < W/8; i++) send_byte(pay[8*i +: 8]);
    collect(exp_q.size(), stall);
    n_chk++;
    if (got_tmo !== 1'b0)
      $display("FAIL %s tx_timeout: got %0d bytes, required %0d",
               tag, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL %s byte%0d: actual %02h required %02h", tag, i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    n_chk++;
    if (err_cnt - e0 !== (bad ? 1 : 0))
      $display("FAIL %s err_pulses: actual %0d required %0d",
               tag, err_cnt - e0, bad ? 1 : 0);
    else n_pass++;
    n_chk++;
    if (dut_out !== model_packed())
      $display("FAIL %s dut_data: actual %h required %h",
               tag, dut_out, model_packed());
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || tx_valid !== 1'b0)
      $display("FAIL %s idle_after: busy %b tx_valid %b required 0 0",
               tag, busy, tx_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (dut_out !== '0 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        busy !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_outputs: dut %h txv %b txd %h busy %b err %b",
               dut_out, tx_valid, tx_data, busy, err);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(2'b10, 6'd0, '0, 0, "reset_snap");
  endtask

  task automatic test_write();
    do_frame(2'b00, 6'd2, 32'h12345678, 0, "write_ch2");
    n_chk++;
    if (dut_out[2*W +: W] !== 32'h12345678)
      $display("FAIL write_ch2_word: actual %h required 12345678",
               dut_out[2*W +: W]);
    else n_pass++;
  endtask

  task automatic test_read_stall();
    dut_in[1*W +: W] = 32'hDEADBEEF;
    do_frame(2'b01, 6'd1, '0, 5, "read_stall");
    n_chk++;
    if (got_unst !== 0)
      $display("FAIL read_stall_stable: actual %0d changes required 0",
               got_unst);
    else n_pass++;
  endtask

  task automatic test_capture();
    dut_in = {32'hAAAA_0003, 32'hBBBB_0002, 32'hCCCC_0001, 32'hDDDD_0000};
    do_frame(2'b11, 6'd17, '0, 0, "capture");
    dut_in = {4{32'h0BAD_F00D}};
    do_frame(2'b10, 6'd3, '0, 1, "snap_ch3");
  endtask

  task automatic test_bad_channel();
    do_frame(2'b01, 6'd9, '0, 0, "read_ch9");
    do_frame(2'b00, 6'd9, 32'hCAFE_F00D, 0, "write_ch9");
  endtask

  task automatic test_timeout();
    int e0, fire;
    logic txseen, busy_early;
    e0 = err_cnt;
    fire = -1;
    txseen = 1'b0;
    busy_early = 1'b1;
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int k = 1; k <= TO + 4; k++) begin
      @(negedge clk);
      if (err && fire < 0) fire = k;
      if (tx_valid) txseen = 1'b1;
      if (k < TO && !busy) busy_early = 1'b0;
    end
    n_chk++;
    if (fire !== TO)
      $display("FAIL timeout_cycle: actual %0d required %0d", fire, TO);
    else n_pass++;
    n_chk++;
    if (err_cnt - e0 !== 1 || txseen !== 1'b0 || busy_early !== 1'b1)
      $display("FAIL timeout_effects: pulses %0d tx %b busy %b req 1 0 1",
               err_cnt - e0, txseen, busy_early);
    else n_pass++;
    dut_in[0 +: W] = 32'h0102_0304;
    do_frame(2'b01, 6'd0, '0, 0, "read_after_to");
  endtask

  task automatic test_reset_mid();
    int e0, w;
    logic seen;
    dut_in[1*W +: W] = 32'h5566_7788;
    send_byte(8'h41);
    w = 0;
    while (!tx_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    e0 = err_cnt;
    send_byte(8'h55);
    @(negedge clk);
    n_chk++;
    if (err_cnt - e0 !== 1 || tx_valid !== 1'b1 || tx_data !== 8'h88)
      $display("FAIL resp_drop: pulses %0d txv %b txd %h req 1 1 88",
               err_cnt - e0, tx_valid, tx_data);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || dut_out !== '0)
      $display("FAIL reset_mid: txv %b busy %b dut %h required 0 0 0",
               tx_valid, busy, dut_out);
    else n_pass++;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL reset_mid_tx: actual tx_valid seen %b required 0",
               seen);
    else n_pass++;
    do_frame(2'b01, 6'd1, '0, 0, "read_after_rst");
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [5:0] ch;
    for (int n = 0; n < 40; n++) begin
      dut_in = {$urandom, $urandom, $urandom, $urandom};
      op = 2'($urandom_range(0, 3));
      ch = ($urandom_range(0, 7) == 7) ? 6'd63
                                       : 6'($urandom_range(0, 5));
      do_frame(op, ch, $urandom, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read_stall();
    test_capture();
    test_bad_channel();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
